// File: rtl/key_event_decoder_pkg.sv
// Shared constants for the key event decoder: event codes, FSM states, key codes.
package key_event_decoder_pkg;

   localparam logic [2:0] EVT_NONE    = 3'd0;
   localparam logic [2:0] EVT_SINGLE0 = 3'd1;
   localparam logic [2:0] EVT_SINGLE1 = 3'd2;
   localparam logic [2:0] EVT_DOUBLE0 = 3'd3;
   localparam logic [2:0] EVT_DOUBLE1 = 3'd4;
   localparam logic [2:0] EVT_CHORD   = 3'd5;

   localparam logic [1:0] KEY_NONE = 2'b00;
   localparam logic [1:0] KEY0     = 2'b01;
   localparam logic [1:0] KEY1     = 2'b10;
   localparam logic [1:0] BOTH     = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   function automatic logic [2:0] single_code(input logic key);
      return key ? EVT_SINGLE1 : EVT_SINGLE0;
   endfunction

   function automatic logic [2:0] double_code(input logic key);
      return key ? EVT_DOUBLE1 : EVT_DOUBLE0;
   endfunction

endpackage

// File: rtl/key_evt_outreg.sv
// One-entry valid/ready event register with a sticky overflow flag.
module key_evt_outreg
   import key_event_decoder_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       evt_load,
   input  logic [2:0] evt_load_code,
   input  logic       evt_ready,
   input  logic       ovf_clr,
   output logic       evt_valid,
   output logic [2:0] evt_code,
   output logic       evt_ovf
);

   logic can_load;
   logic drop;

   assign can_load = !evt_valid || evt_ready;
   assign drop     = evt_load && evt_valid && !evt_ready;

   // Load a new event when the slot is free or being read this cycle; otherwise hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         evt_valid <= 1'b0;
         evt_code  <= EVT_NONE;
      end else if (evt_load && can_load) begin
         evt_valid <= 1'b1;
         evt_code  <= evt_load_code;
      end else if (evt_valid && evt_ready) begin
         evt_valid <= 1'b0;
         evt_code  <= EVT_NONE;
      end
   end

   // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         evt_ovf <= 1'b0;
      end else if (drop) begin
         evt_ovf <= 1'b1;
      end else if (ovf_clr) begin
         evt_ovf <= 1'b0;
      end
   end

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key presses into single, double and chord events.
//
// state | meaning
// IDLE  | no click pending, timer held at 0
// WAIT  | one click of pend_key pending, timer counting the double-click window
module key_event_decoder
   import key_event_decoder_pkg::*;
#(
   parameter int WINDOW_CYCLES = 15_000_000,
   parameter int CNT_W         = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_flag,
   input  logic [1:0] key_value,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [2:0] evt_code,
   output logic       evt_ovf,
   input  logic       ovf_clr
);

   localparam logic [CNT_W-1:0] TC = CNT_W'(WINDOW_CYCLES - 1);

   state_t           state, state_nxt;
   logic             pend_key, pend_key_nxt;
   logic [CNT_W-1:0] timer, timer_nxt;
   logic             new_evt;
   logic [2:0]       new_code;
   logic             press;
   logic             press_key;

   assign press     = key_flag && (key_value != KEY_NONE);
   // For single-key codes (01/10) the upper bit identifies the key.
   assign press_key = key_value[1];

   // State, pending key and window timer registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         pend_key <= 1'b0;
         timer    <= '0;
      end else begin
         state    <= state_nxt;
         pend_key <= pend_key_nxt;
         timer    <= timer_nxt;
      end
   end

   // Next-state and event decision; a press always beats the timeout in the same cycle.
   always_comb begin
      state_nxt    = state;
      pend_key_nxt = pend_key;
      timer_nxt    = timer;
      new_evt      = 1'b0;
      new_code     = EVT_NONE;
      unique case (state)
         IDLE: begin
            timer_nxt = '0;
            if (press) begin
               if (key_value == BOTH) begin
                  new_evt  = 1'b1;
                  new_code = EVT_CHORD;
               end else begin
                  state_nxt    = WAIT;
                  pend_key_nxt = press_key;
               end
            end
         end
         WAIT: begin
            if (press && key_value == BOTH) begin
               new_evt   = 1'b1;
               new_code  = EVT_CHORD;
               state_nxt = IDLE;
               timer_nxt = '0;
            end else if (press && press_key == pend_key) begin
               new_evt   = 1'b1;
               new_code  = double_code(pend_key);
               state_nxt = IDLE;
               timer_nxt = '0;
            end else if (press) begin
               new_evt      = 1'b1;
               new_code     = single_code(pend_key);
               pend_key_nxt = press_key;
               timer_nxt    = '0;
            end else if (timer == TC) begin
               new_evt   = 1'b1;
               new_code  = single_code(pend_key);
               state_nxt = IDLE;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            timer_nxt = '0;
         end
      endcase
   end

   key_evt_outreg u_outreg (
      .clk           (clk),
      .rst_n         (rst_n),
      .evt_load      (new_evt),
      .evt_load_code (new_code),
      .evt_ready     (evt_ready),
      .ovf_clr       (ovf_clr),
      .evt_valid     (evt_valid),
      .evt_code      (evt_code),
      .evt_ovf       (evt_ovf)
   );

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Sits directly downstream of the key debouncer. Consumes its one-cycle key_flag pulse and its key_value code.
- Classifies each press as a single click, a double click or a two-key chord. Uses a click-window timer to tell single clicks from double clicks.
- Presents each classified event to the application control logic through a one-entry valid/ready output register.

Parameters:
- WINDOW_CYCLES, 15_000_000: double-click window in clk cycles (300 ms at 50 MHz). Must be >= 2.
- CNT_W, 24: width of the window timer. Must satisfy 2^CNT_W > WINDOW_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- key_flag  in  1  one-cycle pulse from the debouncer: a debounced press occurred
- key_value  in  2  pressed-key code, valid when key_flag=1; bit set = key pressed; 01=key0, 10=key1, 11=both
- evt_valid  out  1  event register holds an unread event
- evt_ready  in  1  consumer accepts the event this cycle
- evt_code  out  3  1=SINGLE0, 2=SINGLE1, 3=DOUBLE0, 4=DOUBLE1, 5=CHORD; 0 when evt_valid=0
- evt_ovf  out  1  sticky: an event was dropped
- ovf_clr  in  1  clears evt_ovf

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - evt_valid=0, evt_code=0, evt_ovf=0.
  - FSM goes to IDLE; timer=0; pending key cleared.
  - Reset mid-window discards the pending click. No event is emitted.
- Press input: press = key_flag && key_value!=00. key_flag with key_value=00 is ignored.
- FSM states: IDLE, WAIT. In WAIT the FSM stores pend_key (0 or 1) and runs the timer.
- IDLE transitions:
  - press with 01 or 10 -> WAIT; pend_key = the pressed key; timer=0.
  - press with 11 -> emit CHORD; stay in IDLE.
- WAIT, evaluated in priority order each cycle:
  1. press with 11 -> emit CHORD; the pending click is discarded (no SINGLE); go to IDLE.
  2. press of the same key as pend_key -> emit DOUBLE for that key; go to IDLE.
  3. press of the other key -> emit SINGLE for pend_key; pend_key = new key; timer=0; stay in WAIT.
  4. no press and timer==WINDOW_CYCLES-1 -> emit SINGLE for pend_key; go to IDLE.
  5. otherwise timer+1.
- Timeout tie: a press in the same cycle the timer reaches WINDOW_CYCLES-1 counts as inside the window, so the press wins.
- Window length: a second press arriving at most WINDOW_CYCLES cycles after the first press's key_flag cycle is a double click.
- Timer: counts only in WAIT. It never wraps, because leaving WAIT at the terminal count is mandatory.
- Output latency: an event decided on the key_flag cycle t (or the timeout cycle t) appears as evt_valid=1 with evt_code at cycle t+1. It is registered, with no combinational path from inputs to outputs.
- Output handshake:
  - Transfer happens when evt_valid && evt_ready at a clk edge; evt_valid then clears unless a new event loads in that same cycle.
  - evt_valid && evt_ready && new event in the same cycle -> the new event loads; nothing is dropped.
  - evt_valid && !evt_ready && new event -> the new event is dropped; the held event is unchanged; evt_ovf is set.
  - evt_code and evt_valid stay stable while evt_valid=1 and evt_ready=0.
- Overflow flag: ovf_clr clears evt_ovf. A set and a clear in the same cycle -> set wins (evt_ovf=1).
- At most one event is produced per cycle.

Decomposition:
- Shared package: event-code constants (EVT_NONE..EVT_CHORD), the FSM state encoding (IDLE, WAIT) and key-code constants (KEY0=01, KEY1=10, BOTH=11).
- One natural sub-module: key_evt_outreg. It holds the one-entry valid/ready register plus overflow logic.
- The FSM and timer stay in the top module.

Test Plan (WINDOW_CYCLES=8):
- key_flag, key_value=01, no further press, evt_ready=1 -> single-cycle evt_valid with evt_code=1, nine cycles after the press (8 window cycles + 1).
- key0 press, then key0 press 5 cycles later -> one event, code=3, at press2+1; no SINGLE emitted; FSM back in IDLE.
- key0 press, then key1 press 3 cycles later, then idle -> code=1 at press2+1, then code=2 nine cycles after press2.
- Second key0 press exactly 8 cycles after the first (the tie cycle) -> code=3; a press at 9 cycles -> code=1 then a new window opens.
- evt_ready=0: key_value=11 twice, 4 cycles apart -> evt_code holds 5, second event dropped, evt_ovf=1. Then evt_ready=1 for one cycle -> evt_valid=0. Then ovf_clr together with a new drop -> evt_ovf stays 1.
- key1 press, rst_n=0 for one cycle at window cycle 3 -> no event is ever emitted; all outputs 0; the next key1 press restarts normally.
